// File: rtl/reset_ticker_pkg.sv
// Shared constants for the reset ticker: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reset_ticker_pkg;

   // Two-state reset sequencer: HOLD keeps the downstream reset asserted.
   typedef enum logic {
      HOLD = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_US_DIV      = 25;    // 25 MHz clk -> 1 us
   localparam int DEF_MS_DIV      = 1000;  // 1000 us -> 1 ms
   localparam int DEF_STRETCH     = 16;    // minimum reset pulse in clk cycles
   localparam int DEF_DEBOUNCE_MS = 10;    // button must be stable this many ms
   localparam int UPTIME_W        = 16;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reset_ticker_tick_div.sv
// Enabled modulo-DIV counter that pulses tick on its terminal count.
// Latency: tick is combinational from the count register (same cycle as count == DIV-1).
// Backpressure: none; the counter advances on every cycle where en is high.
module tick_div #(
   parameter int DIV   = 25,
   parameter int WIDTH = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV - 1);

   logic [WIDTH-1:0] cnt;

   // A divide-by-one instance sits permanently on its terminal count, so the
   // pulse is masked while reset is held to keep the reset-time outputs quiet.
   assign tick = en && (cnt == LAST) && !reset;

   // Count 0..DIV-1 on enabled cycles and wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/reset_ticker.sv
// Reset sequencer with stretched, debounced-button-driven downstream reset plus us/ms ticks and uptime.
// Latency: rst_out asserts asynchronously on reset, deasserts on the STRETCH-th edge; ticks are single-cycle pulses.
// Backpressure: none; free-running timebase, outputs are not flow-controlled.
module reset_ticker
   import reset_ticker_pkg::*;
#(
   parameter int US_DIV      = DEF_US_DIV,
   parameter int MS_DIV      = DEF_MS_DIV,
   parameter int STRETCH     = DEF_STRETCH,
   parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                btn,
   output logic                rst_out,
   output logic                ready,
   output logic                tick_us,
   output logic                tick_ms,
   output logic [UPTIME_W-1:0] uptime_ms
);

   localparam int US_W = cnt_w(US_DIV);
   localparam int MS_W = cnt_w(MS_DIV);
   localparam int ST_W = cnt_w(STRETCH);
   localparam int DB_W = cnt_w(DEBOUNCE_MS + 1);

   localparam logic [ST_W-1:0] ST_LAST = ST_W'(STRETCH - 1);
   localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_MS);

   state_t            state;
   logic [ST_W-1:0]   stretch;
   logic              btn_m;
   logic              btn_s;
   logic [DB_W-1:0]   db_cnt;
   logic              btn_db;
   logic              btn_db_q;
   logic              btn_db_rise;

   // Microsecond divider free-runs; millisecond divider steps once per us tick.
   tick_div #(.DIV(US_DIV), .WIDTH(US_W)) u_us_div (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .tick  (tick_us)
   );

   tick_div #(.DIV(MS_DIV), .WIDTH(MS_W)) u_ms_div (
      .clk   (clk),
      .reset (reset),
      .en    (tick_us),
      .tick  (tick_ms)
   );

   // Two-flop synchronizer bringing the raw button into the clk domain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_m <= 1'b0;
         btn_s <= 1'b0;
      end else begin
         btn_m <= btn;
         btn_s <= btn_m;
      end
   end

   // Debounce: count whole milliseconds of continuous press, saturating at the threshold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db_cnt <= '0;
      end else if (!btn_s) begin
         db_cnt <= '0;
      end else if (tick_ms && (db_cnt != DB_MAX)) begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   assign btn_db      = (db_cnt == DB_MAX);
   assign btn_db_rise = btn_db && !btn_db_q;

   // Sequencer: stretch reset in HOLD, release into RUN, re-enter HOLD on an accepted press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HOLD;
         stretch   <= '0;
         rst_out   <= 1'b1;
         ready     <= 1'b0;
         uptime_ms <= '0;
         btn_db_q  <= 1'b0;
      end else begin
         btn_db_q <= btn_db;
         case (state)
            HOLD: begin
               uptime_ms <= '0;
               if (btn_db) begin
                  // A held button keeps restarting the stretch window; this also
                  // covers btn_db arriving on the cycle the window would expire.
                  stretch <= '0;
               end else if (stretch == ST_LAST) begin
                  state   <= RUN;
                  stretch <= '0;
                  rst_out <= 1'b0;
                  ready   <= 1'b1;
               end else begin
                  stretch <= stretch + 1'b1;
               end
            end
            RUN: begin
               if (btn_db_rise) begin
                  state     <= HOLD;
                  stretch   <= '0;
                  rst_out   <= 1'b1;
                  ready     <= 1'b0;
                  uptime_ms <= '0;
               end else if (tick_ms) begin
                  uptime_ms <= uptime_ms + 1'b1;
               end
            end
            default: begin
               state   <= HOLD;
               stretch <= '0;
               rst_out <= 1'b1;
               ready   <= 1'b0;
            end
         endcase
      end
   end

endmodule
